// File: rtl/ofm_read_pkg.sv
// rtl/ofm_read_pkg.sv - shared types, FIFO depth and pixel post-processing for the OFM read side
package ofm_read_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, CLEAR} state_t;

  localparam int FIFO_DEPTH = 2;

  // Caller narrows the result to dw bits; the returned value always fits.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input int dw,
                                                  input logic relu);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (relu && v < 64'sd0) return 64'sd0;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// rtl/psum_out_fifo.sv - two-entry FIFO of {last, pixel} between psum capture and the output stream
module psum_out_fifo
  import ofm_read_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk1,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_pop;

  assign do_pop    = pop && (count != 2'd0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ofm_read_data.sv
// rtl/ofm_read_data.sv - drains a finished psum row, applies ReLU/saturation and streams OFM pixels
module ofm_read_data
  import ofm_read_pkg::*;
#(
  parameter int ACC_WIDTH  = 24,
  parameter int DATA_WIDTH = 16,
  parameter int OFM_SIZE   = 7
) (
  input  logic                        clk1,
  input  logic                        rst,
  input  logic                        row_ready,
  input  logic                        relu_en,
  output logic                        rd_en_psum,
  output logic                        rd_psum_clr,
  input  logic signed [ACC_WIDTH-1:0] psum_in,
  output logic [DATA_WIDTH-1:0]       ofm_data,
  output logic                        ofm_valid,
  input  logic                        ofm_ready,
  output logic                        ofm_last,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        row_overrun
);

  localparam int RCW  = $clog2(OFM_SIZE + 1);
  localparam int ROWW = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;

  state_t            state;
  logic [RCW-1:0]    rd_cnt;
  logic [ROWW-1:0]   row_cnt;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        fifo_count;
  logic              pop;
  logic [2:0]        occ;
  logic [DATA_WIDTH-1:0] pix;
  logic [DATA_WIDTH:0]   head;

  assign pop       = ofm_valid & ofm_ready;
  // Occupancy at the end of this cycle before any new strobe lands.
  assign occ       = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign rd_en_psum = (state == READ) && (occ < 3'd2);

  assign rd_psum_clr = (state == CLEAR);
  assign frame_done  = (state == CLEAR) && (row_cnt == ROWW'(OFM_SIZE - 1));
  assign busy        = (state != IDLE);

  assign pix = DATA_WIDTH'(sat_relu(64'(psum_in), DATA_WIDTH, relu_en));

  psum_out_fifo #(.W(DATA_WIDTH + 1)) u_fifo (
    .clk1      (clk1),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, pix}),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count)
  );

  assign ofm_valid = (fifo_count != 2'd0);
  assign ofm_last  = head[DATA_WIDTH];
  assign ofm_data  = head[DATA_WIDTH-1:0];

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rd_cnt        <= '0;
      row_cnt       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      row_overrun   <= 1'b0;
    end else begin
      inflight      <= rd_en_psum;
      inflight_last <= rd_en_psum && (rd_cnt == RCW'(OFM_SIZE - 1));
      if (row_ready && state != IDLE) row_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (row_ready) begin
            state  <= READ;
            rd_cnt <= '0;
          end
        end
        READ: begin
          if (rd_en_psum) begin
            rd_cnt <= rd_cnt + RCW'(1);
            if (rd_cnt == RCW'(OFM_SIZE - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (occ == 3'd0) state <= CLEAR;
        end
        CLEAR: begin
          state   <= IDLE;
          row_cnt <= (row_cnt == ROWW'(OFM_SIZE - 1)) ? '0 : row_cnt + ROWW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_read_data.sv
// tb/tb_ofm_read_data.sv - scoreboard bench for ofm_read_data
module tb_ofm_read_data;

  logic               clk1;
  logic               rst;
  logic               row_ready;
  logic               relu_en;
  logic               rd_en_psum;
  logic               rd_psum_clr;
  logic signed [23:0] psum_in;
  logic [15:0]        ofm_data;
  logic               ofm_valid;
  logic               ofm_ready;
  logic               ofm_last;
  logic               frame_done;
  logic               busy;
  logic               row_overrun;

  ofm_read_data #(.ACC_WIDTH(24), .DATA_WIDTH(16), .OFM_SIZE(7)) dut (
    .clk1        (clk1),
    .rst         (rst),
    .row_ready   (row_ready),
    .relu_en     (relu_en),
    .rd_en_psum  (rd_en_psum),
    .rd_psum_clr (rd_psum_clr),
    .psum_in     (psum_in),
    .ofm_data    (ofm_data),
    .ofm_valid   (ofm_valid),
    .ofm_ready   (ofm_ready),
    .ofm_last    (ofm_last),
    .frame_done  (frame_done),
    .busy        (busy),
    .row_overrun (row_overrun)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int mem [7];
  logic [16:0] exp_q [$];
  int n_assert, n_fail;
  int cyc, ptr, strobes, accepted, beats;
  int first_rd, first_valid, last_cyc, clr_cyc, fd_cnt, fd_cyc;
  int bp_k;
  bit bp_mode;

  function automatic logic [15:0] exp_pix(input int v, input logic r);
    if (r && v < 0) return 16'd0;
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic tick();
    bit s, c, p;
    int tmp;
    logic [16:0] e;
    @(negedge clk1);
    cyc++;
    p = ofm_valid && ofm_ready;
    s = rd_en_psum;
    c = rd_psum_clr;
    if (s) begin
      n_assert++;
      if ((strobes - accepted) >= 2 && !p) begin
        n_fail++;
        $display("FAIL overflow_guard cycle %0d: rd_en_psum=1 with %0d outstanding and no pop, required 0", cyc, strobes - accepted);
      end
      if (first_rd < 0) first_rd = cyc;
    end
    if (p) begin
      if (first_valid < 0) first_valid = cyc;
      beats++;
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected cycle %0d: got {last,data}=%h, required no beat", cyc, {ofm_last, ofm_data});
      end else begin
        e = exp_q.pop_front();
        if ({ofm_last, ofm_data} !== e) begin
          n_fail++;
          $display("FAIL beat_data cycle %0d: got {last,data}=%h, required %h", cyc, {ofm_last, ofm_data}, e);
        end
      end
      if (ofm_last) last_cyc = cyc;
      accepted++;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (c) clr_cyc = cyc;
    @(posedge clk1);
    #1;
    row_ready = 1'b0;
    if (s) begin
      tmp = (ptr < 7) ? mem[ptr] : 0;
      psum_in = tmp[23:0];
      exp_q.push_back({ptr == 6, exp_pix(tmp, relu_en)});
      ptr++;
      strobes++;
    end
    if (c) ptr = 0;
    bp_k++;
    ofm_ready = bp_mode ? (bp_k % 3 == 0) : 1'b1;
  endtask

  task automatic run_row(input int pulse_off, input bit chk_timing, input int budget);
    int t0, n, s0;
    beats = 0; first_rd = -1; first_valid = -1; last_cyc = -1; clr_cyc = -1;
    s0 = strobes;
    bp_k = 0;
    ofm_ready = 1'b1;
    row_ready = 1'b1;
    t0 = cyc + 1;
    n = 0;
    while (clr_cyc < 0 && n < budget) begin
      if (pulse_off > 0 && n == pulse_off) row_ready = 1'b1;
      tick();
      n++;
    end
    n_assert++;
    if (clr_cyc < 0) begin
      n_fail++;
      $display("FAIL row_timeout: no rd_psum_clr within %0d cycles, required one", budget);
    end
    n_assert++;
    if (beats != 7) begin
      n_fail++;
      $display("FAIL beat_count: got %0d beats, required 7", beats);
    end
    n_assert++;
    if (strobes - s0 != 7) begin
      n_fail++;
      $display("FAIL strobe_count: got %0d strobes, required 7", strobes - s0);
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected beats never delivered, required 0", exp_q.size());
    end
    n_assert++;
    if (clr_cyc != last_cyc + 1) begin
      n_fail++;
      $display("FAIL clr_after_last: clr cycle %0d, required %0d", clr_cyc, last_cyc + 1);
    end
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_clr: got %b, required 0", busy);
    end
    if (chk_timing) begin
      n_assert++;
      if (first_rd != t0 + 1 || first_valid != t0 + 3 || last_cyc != t0 + 9 || clr_cyc != t0 + 10) begin
        n_fail++;
        $display("FAIL row_timing: rd/valid/last/clr at +%0d/+%0d/+%0d/+%0d, required +1/+3/+9/+10",
                 first_rd - t0, first_valid - t0, last_cyc - t0, clr_cyc - t0);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_assert++;
    if ({rd_en_psum, rd_psum_clr, ofm_data, ofm_valid, ofm_last, frame_done, busy, row_overrun} !== 23'd0) begin
      n_fail++;
      $display("FAIL %s: outputs {rd,clr,data,valid,last,fd,busy,ovr}=%h, required 0", tag,
               {rd_en_psum, rd_psum_clr, ofm_data, ofm_valid, ofm_last, frame_done, busy, row_overrun});
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    exp_q.delete();
    ptr = 0; strobes = 0; accepted = 0;
    @(posedge clk1);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    check_idle_outputs("reset_held");
    rst = 1'b0;
    @(posedge clk1);
    #1;
    check_idle_outputs("reset_released");
  endtask

  task automatic test_basic();
    for (int i = 0; i < 7; i++) mem[i] = i + 1;
    relu_en = 1'b0;
    run_row(0, 1'b1, 40);
  endtask

  task automatic test_saturation();
    mem[0] = 40000; mem[1] = -40000; mem[2] = -5; mem[3] = 5;
    mem[4] = 32768; mem[5] = -32769; mem[6] = -32768;
    relu_en = 1'b0;
    run_row(0, 1'b1, 40);
    relu_en = 1'b1;
    run_row(0, 1'b1, 40);
    relu_en = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 7; i++) mem[i] = 1000 * (i + 1) - 3500;
    bp_mode = 1'b1;
    run_row(0, 1'b0, 80);
    bp_mode = 1'b0;
  endtask

  task automatic test_frame();
    int f0;
    bit exp_fd;
    apply_reset();
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 7; i++) mem[i] = r * 10 + i;
      f0 = fd_cnt;
      run_row(0, 1'b1, 40);
      exp_fd = (r % 7 == 0);
      n_assert++;
      if ((fd_cnt - f0) != (exp_fd ? 1 : 0)) begin
        n_fail++;
        $display("FAIL frame_done_count row %0d: got %0d pulses, required %0d", r, fd_cnt - f0, exp_fd);
      end
      if (exp_fd) begin
        n_assert++;
        if (fd_cyc != clr_cyc) begin
          n_fail++;
          $display("FAIL frame_done_cycle row %0d: at cycle %0d, required %0d", r, fd_cyc, clr_cyc);
        end
      end
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 7; i++) mem[i] = -(i * 3);
    run_row(2, 1'b1, 40);
    n_assert++;
    if (row_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b, required 1", row_overrun);
    end
    run_row(0, 1'b1, 40);
    n_assert++;
    if (row_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %b, required 1", row_overrun);
    end
  endtask

  task automatic test_reset_mid_row();
    int n;
    for (int i = 0; i < 7; i++) mem[i] = 7 - i;
    beats = 0; clr_cyc = -1;
    row_ready = 1'b1;
    n = 0;
    while (beats < 3 && n < 20) begin
      tick();
      n++;
    end
    n_assert++;
    if (beats != 3 || clr_cyc >= 0) begin
      n_fail++;
      $display("FAIL pre_reset_progress: beats=%0d clr_cyc=%0d, required 3 beats and no clear", beats, clr_cyc);
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid_row");
    exp_q.delete();
    ptr = 0; strobes = 0; accepted = 0;
    @(posedge clk1);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) mem[i] = 101 + i;
    run_row(0, 1'b1, 40);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0; ptr = 0; strobes = 0; accepted = 0;
    fd_cnt = 0; fd_cyc = -1; bp_k = 0; bp_mode = 1'b0;
    rst = 1'b1; row_ready = 1'b0; relu_en = 1'b0; psum_in = '0; ofm_ready = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_frame();
    test_overrun();
    test_reset_mid_row();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ofm_read_data.md
# ofm_read_data

Read-side controller for the partial-sum buffer: once the write-side controller has finished accumulating the last input channel of an output row, this block reads the OFM_SIZE finished sums out of the buffer. It post-processes each sum (optional ReLU, signed saturation to DATA_WIDTH) and streams it on a valid/ready output interface. When the row is drained it clears the buffer read pointer and counts rows to flag frame completion. It sits between the psum buffer and the output feature-map writer.

## Interface
- ACC_WIDTH, 24, signed width of a stored partial sum
- DATA_WIDTH, 16, signed width of an output pixel
- OFM_SIZE, 7, pixels per OFM row and rows per OFM frame
- clk1  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- row_ready  in  1  one-cycle pulse: a complete, last-channel row is in the psum buffer
- relu_en  in  1  quasi-static; 1 = clamp negative sums to 0
- rd_en_psum  out  1  psum buffer read strobe; data returns on psum_in one cycle later
- rd_psum_clr  out  1  one-cycle pulse resetting the buffer read pointer
- psum_in  in  ACC_WIDTH  read data from psum buffer
- ofm_data  out  DATA_WIDTH  output pixel
- ofm_valid  out  1  ofm_data valid
- ofm_ready  in  1  downstream accepts the current beat
- ofm_last  out  1  qualifies the last pixel of a row
- frame_done  out  1  one-cycle pulse after row OFM_SIZE-1 is cleared
- busy  out  1  high in any state other than IDLE
- row_overrun  out  1  sticky error: row_ready seen while busy

## Operation
- States: IDLE, READ, DRAIN, CLEAR.
- IDLE, with row_ready = 1: go to READ and reset the read counter.
- READ: assert rd_en_psum whenever fifo_count + inflight − pop < 2.
  - inflight = rd_en_psum of the previous cycle.
  - pop = ofm_valid & ofm_ready.
  - After OFM_SIZE strobes, go to DRAIN.
- DRAIN: wait until fifo_count == 0 and inflight == 0, then go to CLEAR.
- CLEAR, one cycle:
  - rd_psum_clr = 1.
  - row_cnt increments.
  - If row_cnt was OFM_SIZE−1: it wraps to 0 and frame_done pulses in the same cycle.
  - Next state is IDLE.
- Capture: when inflight = 1, psum_in is processed and pushed into a 2-entry FIFO together with a last flag (the read index was OFM_SIZE−1).
- Processing:
  - If relu_en = 1 and psum < 0, the result is 0.
  - Otherwise the value is saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Otherwise the value is truncated to the low DATA_WIDTH bits (the value already fits).
- Output: ofm_data, ofm_valid and ofm_last come from the FIFO head. The beat holds stable while ofm_valid & !ofm_ready.
- row_ready outside IDLE is ignored and sets row_overrun; it clears only on reset.
- Reset value of every output: 0. FIFO empty, state IDLE, row_cnt 0.
- Reset mid-row: data in flight and in the FIFO is discarded. No rd_psum_clr is issued.

## Timing
- row_ready high in cycle 0 → rd_en_psum first high in cycle 1 → psum_in valid in cycle 2 → ofm_valid first high in cycle 3.
- With ofm_ready held at 1: OFM_SIZE beats in consecutive cycles 3..3+OFM_SIZE−1, and ofm_last on the final beat.
- rd_psum_clr is asserted in the cycle after the last beat is accepted. busy falls in the following cycle.
- Backpressure: at most 2 outstanding (FIFO + inflight). rd_en_psum is never asserted when it would overflow the FIFO, and no beat is lost or duplicated.
- A push and a pop in the same cycle are both performed; the count is unchanged.
- The earliest accepted next row_ready is the first cycle in IDLE.

## Structure
- Shared package ofm_read_pkg: state enum (IDLE, READ, DRAIN, CLEAR) and FIFO_DEPTH = 2.
- Sub-module psum_out_fifo: 2-entry FIFO of {last, DATA_WIDTH data} with push/pop/count. Everything else stays in the top.
- Saturation/ReLU is a combinational function in the package.

## Test plan
- Basic row: ofm_ready = 1, relu_en = 0, psum values 1..7, row_ready in cycle 0 → ofm_data 1..7 in cycles 3..9, ofm_last in cycle 9, rd_psum_clr in cycle 10.
- Saturation/ReLU: psums 40000, −40000, −5, 5.
  - relu_en = 0 → 32767, −32768, −5, 5.
  - relu_en = 1 → 32767, 0, 0, 5.
- Backpressure: ofm_ready toggles 1,0,0,1,… → stream in order, exactly 7 beats. rd_en_psum is never high while fifo_count + inflight = 2 and no pop occurs.
- Frame: 7 rows back-to-back → frame_done pulses once, in the CLEAR cycle of row 7; row_cnt is 0 afterwards.
- Overrun: row_ready pulsed in READ → row_overrun = 1 and stays 1. The current row completes normally with 7 beats.
- Reset mid-row: rst asserted after beat 3 → all outputs 0 immediately. The next row_ready yields 7 fresh beats with no stale data.
